// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared types and constants for the instruction fetch stage
package if_stage_pkg;
  localparam int PC_W = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction
endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction memory request/response bundle
interface if_stage_if;
  import if_stage_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/if_stage_if_id_reg.sv
// rtl/if_stage_if_id_reg.sv - IF/ID pipeline register with write enable and flush-to-bubble
module if_id_reg import if_stage_pkg::*; (
  input  logic            clk,
  input  logic            reset,
  input  logic            write_en,
  input  logic            flush,
  input  logic [PC_W-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     instr,
  output logic            valid
);
  // A bubble keeps the previous pc; only instr and valid are replaced.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= '0;
      instr <= NOP;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP;
      valid <= 1'b0;
    end else if (write_en) begin
      pc    <= pc_in;
      instr <= instr_in;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, fetch FSM and one-entry stall buffer
module if_stage import if_stage_pkg::*; #(
  parameter logic [PC_W-1:0] RESET_PC = 64'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable_PCWrite,
  input  logic            enable_Write,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  if_stage_if.master      imem,
  output logic [PC_W-1:0] ifid_pc,
  output logic [31:0]     ifid_instr,
  output logic            ifid_valid
);
  fetch_state_t    state, next_state;
  logic [PC_W-1:0] pc, pc_d, buf_pc, drain_addr, req_addr;
  logic [31:0]     buf_instr;
  logic            req, pc_load, buf_load, drain_load, id_write, id_flush, from_buf;
  logic            advance;

  assign advance        = enable_Write && enable_PCWrite;
  assign imem.imem_req  = req;
  assign imem.imem_addr = req_addr;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_REQ;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    req        = 1'b0;
    req_addr   = pc;
    pc_load    = 1'b0;
    pc_d       = pc;
    buf_load   = 1'b0;
    drain_load = 1'b0;
    id_write   = 1'b0;
    id_flush   = 1'b0;
    from_buf   = 1'b0;
    unique case (state)
      ST_REQ: begin
        req = 1'b1;
        if (imem.imem_ready) begin
          if (advance) begin
            id_write = 1'b1;
            pc_load  = 1'b1;
            pc_d     = pc_inc(pc);
          end else begin
            buf_load   = 1'b1;
            next_state = ST_HOLD;
          end
        end else if (enable_Write) begin
          id_flush = 1'b1;
        end
      end
      ST_HOLD: begin
        if (advance) begin
          id_write   = 1'b1;
          from_buf   = 1'b1;
          pc_load    = 1'b1;
          pc_d       = pc_inc(pc);
          next_state = ST_REQ;
        end
      end
      ST_DRAIN: begin
        // The abandoned request keeps its original address until it completes.
        req      = 1'b1;
        req_addr = drain_addr;
        if (imem.imem_ready) next_state = ST_REQ;
      end
      default: next_state = ST_REQ;
    endcase

    // Redirect overrides every stall decision made above.
    if (branch_taken) begin
      id_write = 1'b0;
      id_flush = 1'b1;
      buf_load = 1'b0;
      pc_load  = 1'b1;
      pc_d     = branch_target & ~PC_W'(3);
      if (state == ST_HOLD || imem.imem_ready) begin
        next_state = ST_REQ;
      end else begin
        next_state = ST_DRAIN;
        drain_load = (state == ST_REQ);
      end
    end
  end

  // HOLD state itself marks the buffer as valid, so no separate valid bit.
  always_ff @(posedge clk) begin
    if (reset)        pc <= RESET_PC;
    else if (pc_load) pc <= pc_d;
    if (buf_load) begin
      buf_pc    <= pc;
      buf_instr <= imem.imem_rdata;
    end
    if (drain_load) drain_addr <= pc;
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .write_en (id_write),
    .flush    (id_flush),
    .pc_in    (from_buf ? buf_pc : pc),
    .instr_in (from_buf ? buf_instr : imem.imem_rdata),
    .pc       (ifid_pc),
    .instr    (ifid_instr),
    .valid    (ifid_valid)
  );
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage against a flag-based fetch model
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst, ew, ep, br;
  logic [63:0] bt;
  logic [63:0] ifid_pc, ifid_pc2;
  logic [31:0] ifid_instr, ifid_instr2;
  logic        ifid_valid, ifid_valid2;

  if_stage_if bus ();
  if_stage_if bus2 ();

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(64'h0)) dut (
    .clk(clk), .reset(rst), .enable_PCWrite(ep), .enable_Write(ew),
    .branch_taken(br), .branch_target(bt), .imem(bus),
    .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid)
  );

  if_stage #(.RESET_PC(WRAP_PC)) dut2 (
    .clk(clk), .reset(rst), .enable_PCWrite(1'b1), .enable_Write(1'b1),
    .branch_taken(1'b0), .branch_target(64'h0), .imem(bus2),
    .ifid_pc(ifid_pc2), .ifid_instr(ifid_instr2), .ifid_valid(ifid_valid2)
  );

  // Zero-wait memory for the wrap-around instance.
  assign bus2.imem_ready = bus2.imem_req;
  assign bus2.imem_rdata = bus2.imem_addr[31:0] ^ 32'h1234_5678;

  int checks = 0;
  int errors = 0;
  int mcnt = 0, mlat = 0, lat_cfg = 0;
  int vcount;

  // Reference model: what IF/ID and the memory port should show, in fetch terms.
  bit          m_ok = 1'b0;
  logic [63:0] m_pc, m_buf_pc, m_stale_addr, m_vpc;
  logic [31:0] m_buf_instr, m_vinstr;
  logic        m_buf_full, m_stale, m_valid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic e_w, input logic e_p,
                      input logic b, input logic [63:0] t);
    logic        rdy;
    logic [31:0] rd;
    if (m_ok) begin
      chk("imem_req", bus.imem_req, !m_buf_full);
      if (!m_buf_full) chk("imem_addr", bus.imem_addr, m_stale ? m_stale_addr : m_pc);
      chk("ifid_valid", ifid_valid, m_valid);
      chk("ifid_pc", ifid_pc, m_vpc);
      chk("ifid_instr", ifid_instr, m_vinstr);
    end
    rdy = 1'b0;
    rd  = $urandom;
    if (bus.imem_req === 1'b1) begin
      if (mcnt >= mlat) begin
        rdy  = 1'b1;
        mcnt = 0;
        mlat = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      end else mcnt++;
    end else mcnt = 0;
    if (r) mcnt = 0;
    rst = r; ew = e_w; ep = e_p; br = b; bt = t;
    bus.imem_ready = rdy;
    bus.imem_rdata = rd;

    if (r) begin
      m_pc = 64'h0; m_buf_full = 1'b0; m_stale = 1'b0;
      m_valid = 1'b0; m_vpc = 64'h0; m_vinstr = NOP; m_ok = 1'b1;
    end else if (b) begin
      // An in-flight fetch not completing now becomes a response to throw away.
      if (!m_buf_full && !rdy) begin
        if (!m_stale) m_stale_addr = m_pc;
        m_stale = 1'b1;
      end else m_stale = 1'b0;
      m_pc = t & ~64'h3; m_buf_full = 1'b0; m_valid = 1'b0; m_vinstr = NOP;
    end else if (m_stale) begin
      if (rdy) m_stale = 1'b0;
    end else if (m_buf_full) begin
      if (e_w && e_p) begin
        m_vpc = m_buf_pc; m_vinstr = m_buf_instr; m_valid = 1'b1;
        m_pc = m_pc + 64'd4; m_buf_full = 1'b0;
      end
    end else if (rdy) begin
      if (e_w && e_p) begin
        m_vpc = m_pc; m_vinstr = rd; m_valid = 1'b1; m_pc = m_pc + 64'd4;
      end else begin
        m_buf_full = 1'b1; m_buf_pc = m_pc; m_buf_instr = rd;
      end
    end else if (e_w) begin
      m_valid = 1'b0; m_vinstr = NOP;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ew = 1'b1; ep = 1'b1; br = 1'b0; bt = 64'h0;
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
    lat_cfg = 0; mlat = 0;

    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("rst_valid", ifid_valid, 1'b0);
    chk("rst_pc", ifid_pc, 64'h0);
    chk("rst_instr", ifid_instr, NOP);
    chk("rst_req", bus.imem_req, 1'b1);
    chk("rst_addr", bus.imem_addr, 64'h0);
    chk("wrap_addr0", bus2.imem_addr, WRAP_PC);

    // Zero-wait memory, no stalls: one instruction per cycle.
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 1, 0, 0);
      chk("zw_pc", ifid_pc, 64'(4 * k));
      chk("zw_valid", ifid_valid, 1'b1);
      if (k == 0) begin
        chk("wrap_addr1", bus2.imem_addr, 64'h0);
        chk("wrap_ifid_pc", ifid_pc2, WRAP_PC);
      end
    end

    // Two-cycle latency: one valid entry every three cycles.
    lat_cfg = 2; mlat = 2;
    vcount = 0;
    for (int k = 0; k < 9; k++) begin
      step(0, 1, 1, 0, 0);
      if (ifid_valid) vcount++;
    end
    chk("lat2_valid_count", 64'(vcount), 64'd3);

    // Stall on the word at pc=8, then release.
    step(1, 1, 1, 0, 0);
    lat_cfg = 0; mlat = 0;
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("hold_req", bus.imem_req, 1'b0);
    chk("hold_ifid_pc", ifid_pc, 64'h4);
    step(0, 0, 0, 0, 0);
    chk("hold2_ifid_pc", ifid_pc, 64'h4);
    step(0, 1, 1, 0, 0);
    chk("release_ifid_pc", ifid_pc, 64'h8);
    chk("release_valid", ifid_valid, 1'b1);
    chk("release_addr", bus.imem_addr, 64'hC);

    // Redirect while a three-cycle fetch is in flight.
    mlat = 3; mcnt = 0;
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 64'h103);
    chk("drain_req", bus.imem_req, 1'b1);
    chk("drain_addr", bus.imem_addr, 64'hC);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("redirect_addr", bus.imem_addr, 64'h100);
    chk("redirect_valid", ifid_valid, 1'b0);

    // Redirect coinciding with a response while stalled.
    step(0, 0, 0, 1, 64'h200);
    chk("br_rdy_valid", ifid_valid, 1'b0);
    chk("br_rdy_instr", ifid_instr, NOP);
    chk("br_rdy_addr", bus.imem_addr, 64'h200);

    // Reset in the middle of a request.
    lat_cfg = 3; mlat = 3;
    step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("midrst_addr", bus.imem_addr, 64'h0);
    chk("midrst_req", bus.imem_req, 1'b1);

    // Randomized traffic.
    lat_cfg = -1;
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           {$urandom, $urandom});
    end
    step(0, 1, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the PC value loaded on reset.
REQ-002 Port clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  in  1  SHALL be the synchronous, active-high reset.
REQ-004 Port enable_PCWrite  in  1  SHALL be the hazard-unit PC-write enable; 0 = hold PC.
REQ-005 Port enable_Write  in  1  SHALL be the hazard-unit IF/ID write enable; 0 = hold IF/ID.
REQ-006 Port branch_taken  in  1  SHALL be the redirect request from EX; 1 = flush and redirect.
REQ-007 Port branch_target  in  64  SHALL be the redirect PC; bits [1:0] are ignored and treated as 0.
REQ-008 Port imem_req  out  1  SHALL be the instruction-memory request, level-held until imem_ready.
REQ-009 Port imem_addr  out  64  SHALL be the fetch address; stable while imem_req=1.
REQ-010 Port imem_ready  in  1  SHALL be a one-cycle response strobe; may assert in the same cycle as imem_req.
REQ-011 Port imem_rdata  in  32  SHALL be the instruction word; valid only when imem_ready=1.
REQ-012 Ports ifid_pc (out 64), ifid_instr (out 32) and ifid_valid (out 1) SHALL form the IF/ID register contents.

Function
REQ-013 FSM states SHALL be REQ (request outstanding), HOLD (word buffered, IF/ID stalled) and DRAIN (discarding a response after a flush).
REQ-014 In REQ: imem_req=1 and imem_addr=pc; in HOLD and DRAIN, imem_req=0 except DRAIN keeps imem_req=1 with the old address until imem_ready.
REQ-015 REQ with imem_ready=1, enable_Write=1 and enable_PCWrite=1: IF/ID <= {pc, imem_rdata, valid=1}, pc <= pc+4, stay in REQ; latency is 0 cycles from ready to IF/ID load.
REQ-016 REQ with imem_ready=1 and either enable at 0: the word and PC are captured in a one-entry buffer, IF/ID and PC are held, and the FSM goes to HOLD.
REQ-017 REQ with imem_ready=0: when enable_Write=1, IF/ID loads a bubble (valid=0, instr=32'h00000013, pc unchanged); when enable_Write=0, IF/ID is held.
REQ-018 HOLD with both enables at 1: IF/ID loads from the buffer with valid=1, pc <= pc+4, and the FSM goes to REQ; otherwise everything is held.
REQ-019 branch_taken=1 SHALL take priority over stalls:
- pc <= {branch_target[63:2], 2'b00}
- IF/ID <= bubble
- buffer invalidated
- next state is REQ if no request is outstanding or imem_ready=1 this cycle, else DRAIN
- any coincident response is discarded
REQ-020 DRAIN on imem_ready=1: the response is discarded and the FSM goes to REQ; a branch_taken during DRAIN updates pc and the FSM stays in DRAIN.
REQ-021 pc+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 64'h0).
REQ-022 Priority SHALL be reset > branch_taken > stall > normal advance.
REQ-023 At most one memory request SHALL be outstanding at any time.

Reset
REQ-024 On reset=1 at a clock edge:
- pc=RESET_PC
- state=REQ
- buffer invalid
- ifid_valid=0, ifid_pc=0, ifid_instr=32'h00000013
REQ-025 In the first cycle after reset, imem_req=1 and imem_addr=RESET_PC.
REQ-026 Reset during an outstanding request SHALL abandon it; the memory model must tolerate imem_req dropping without imem_ready.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, the NOP constant 32'h00000013 and the PC width of 64.
REQ-028 The IF/ID register (write enable, flush to bubble) SHALL be a sub-module named if_id_reg; the FSM, PC and buffer stay in if_stage.

Verification
REQ-029 Zero-wait memory (ready=rdata same cycle), no stalls, RESET_PC=0 -> ifid_pc = 0, 4, 8, ... on consecutive cycles with ifid_valid=1.
REQ-030 Memory with 2-cycle latency -> one valid IF/ID entry every 3 cycles, bubbles (NOP, valid=0) between entries.
REQ-031 enable_Write=enable_PCWrite=0 in the cycle imem_ready returns the word at pc=8 -> FSM enters HOLD, IF/ID unchanged, imem_req=0; on release, IF/ID gets pc=8 next cycle and the next fetch address is 12.
REQ-032 branch_taken with target 64'h103 while a 3-cycle request is in flight -> DRAIN, stale word never reaches IF/ID, next request address is 64'h100.
REQ-033 branch_taken and imem_ready in the same cycle while stalled -> word discarded, IF/ID shows a bubble, fetch restarts at the target.
REQ-034 pc forced near wrap (RESET_PC=64'hFFFF_FFFF_FFFF_FFFC) -> second fetch address is 64'h0; reset asserted mid-request -> imem_addr=RESET_PC the next cycle.
